// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: widths, opcodes and the
// flag-update class of each opcode.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  typedef enum logic [1:0] {
    FLAGS_NONE = 2'd0,
    FLAGS_Z    = 2'd1,
    FLAGS_ALL  = 2'd2
  } flag_cls_e;

  function automatic flag_cls_e flag_class(input logic [3:0] op);
    flag_cls_e cls;
    cls = FLAGS_NONE;
    case (op)
      OP_ADD, OP_SUB:                 cls = FLAGS_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = FLAGS_Z;
      default:                        cls = FLAGS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural Z/V/N flag register with an independent
// load enable per flag.
module flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic z_en_i,
  input  logic v_en_i,
  input  logic n_en_i,
  input  logic z_d_i,
  input  logic v_d_i,
  input  logic n_d_i,
  output logic z_o,
  output logic v_o,
  output logic n_o
);

  logic z_q, v_q, n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      if (z_en_i) z_q <= z_d_i;
      if (v_en_i) v_q <= v_d_i;
      if (n_en_i) n_q <= n_d_i;
    end
  end

  assign z_o = z_q;
  assign v_o = v_q;
  assign n_o = n_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register with stall/flush handling;
// also owns the architectural flag register.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              ex_reg_wen,
  input  logic              ex_mem_wen,
  input  logic              ex_mem_ren,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_wr_reg,
  output logic              mem_reg_wen,
  output logic              mem_mem_wen,
  output logic              mem_mem_ren,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] sdata_q;
  logic [REG_AW-1:0] wr_reg_q;
  logic              reg_wen_q;
  logic              mem_wen_q;
  logic              mem_ren_q;

  logic      capture;
  logic      upd;
  flag_cls_e cls;
  logic      z_en, v_en, n_en;

  assign capture = !flush && !stall;
  assign upd     = capture && ex_valid;
  assign cls     = flag_class(ex_opcode);

  always_comb begin
    z_en = 1'b0;
    v_en = 1'b0;
    n_en = 1'b0;
    if (upd) begin
      unique case (1'b1)
        (cls == FLAGS_ALL): begin
          z_en = 1'b1;
          v_en = 1'b1;
          n_en = 1'b1;
        end
        (cls == FLAGS_Z): z_en = 1'b1;
        default: ;
      endcase
    end
  end

  // Data fields may keep stale values on flush; only the
  // valid bit and enables must become a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      sdata_q   <= '0;
      wr_reg_q  <= '0;
      reg_wen_q <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      reg_wen_q <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
    end else if (!stall) begin
      valid_q   <= ex_valid;
      result_q  <= ex_result;
      sdata_q   <= ex_store_data;
      wr_reg_q  <= ex_wr_reg;
      reg_wen_q <= ex_reg_wen && ex_valid;
      mem_wen_q <= ex_mem_wen && ex_valid;
      mem_ren_q <= ex_mem_ren && ex_valid;
    end
  end

  flag_reg u_flags (
    .clk    (clk),
    .rst    (rst),
    .z_en_i (z_en),
    .v_en_i (v_en),
    .n_en_i (n_en),
    .z_d_i  (ex_result == '0),
    .v_d_i  (ex_ovfl),
    .n_d_i  (ex_result[DATA_W-1]),
    .z_o    (flag_z),
    .v_o    (flag_v),
    .n_o    (flag_n)
  );

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_store_data = sdata_q;
  assign mem_wr_reg     = wr_reg_q;
  assign mem_reg_wen    = reg_wen_q;
  assign mem_mem_wen    = mem_wen_q;
  assign mem_mem_ren    = mem_ren_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline register for the 16-bit core; sits directly downstream of the execute datapath (Shifter/ALU output mux).
- Captures the execute result plus destination and control bits each cycle.
- Owns the architectural flag register (Z, V, N), updated per opcode class.
- Supports pipeline stall (hold) and flush (bubble insert) from hazard control.

Parameters:
DATA_W, 16, datapath width (result, store data)
REG_AW, 4, register-file address width

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  execute slot holds a real instruction
ex_opcode  in  4  opcode of execute-stage instruction
ex_result  in  DATA_W  ALU/shifter result
ex_ovfl  in  1  signed overflow from ADD/SUB datapath
ex_store_data  in  DATA_W  rt value for SW
ex_wr_reg  in  REG_AW  destination register
ex_reg_wen  in  1  instruction writes register file
ex_mem_wen  in  1  instruction is a store
ex_mem_ren  in  1  instruction is a load
stall  in  1  hold all stage state
flush  in  1  replace captured instruction with bubble
mem_valid  out  1  memory slot holds a real instruction
mem_result  out  DATA_W  registered result / memory address
mem_store_data  out  DATA_W  registered store data
mem_wr_reg  out  REG_AW  registered destination
mem_reg_wen  out  1  registered, gated by mem_valid
mem_mem_wen  out  1  registered, gated by mem_valid
mem_mem_ren  out  1  registered, gated by mem_valid
flag_z  out  1  zero flag
flag_v  out  1  overflow flag
flag_n  out  1  negative flag

Behaviour:
- Reset (async, rst=1): every output 0 immediately, no clock needed; held while rst high.
- Latency: one cycle; values at inputs on edge k appear on outputs after edge k.
- Per rising edge, priority flush > stall > capture:
  - flush=1: mem_valid<=0; mem_reg_wen, mem_mem_wen, mem_mem_ren <= 0; data fields may keep old value; flags unchanged.
  - stall=1 (flush=0): all registers, flags included, hold.
  - otherwise: capture all ex_* fields; mem_valid<=ex_valid; the three enables <= ex_* enable AND ex_valid.
- Enables are never 1 while mem_valid=0 (invariant checked by bench).
- Flag update happens only on capture with ex_valid=1:
  - ADD 0000, SUB 0001: Z<=(ex_result==0), N<=ex_result[15], V<=ex_ovfl.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z<=(ex_result==0); N, V hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, branches, HLT): all flags hold.
- Bubble (ex_valid=0) captured: no flag change, mem_valid=0.
- Flags are visible to branch evaluation the cycle after capture; no internal bypass.
- Reset deasserted mid-stall: outputs stay 0 until first capture edge.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_ADD..OP_HLT), DATA_W, REG_AW, flag-update class function/constants (FLAGS_ALL, FLAGS_Z, FLAGS_NONE).
- One sub-module flag_reg: holds Z/V/N with per-flag enables, async reset; ex_mem_stage decodes opcode into the enables.

Test Plan:
- Reset: assert rst mid-cycle with mem_valid=1, flag_z=1 -> all outputs 0 before next edge.
- ADD, result 0x8000, ex_ovfl=1, valid -> next cycle mem_result=0x8000, N=1, V=1, Z=0; then SLL result 0x0000 -> Z=1, N=1, V=1 held.
- stall=1 for 3 cycles with changing ex_* and an ADD of 0 -> outputs and flags frozen; stall release captures current ex_* next edge.
- flush=1 and stall=1 together with a SW (mem_wen=1) -> mem_valid=0, mem_mem_wen=0, flags unchanged.
- ex_valid=0, ex_reg_wen=1, opcode SUB, result 0 -> mem_reg_wen=0, Z unchanged.
- Back-to-back LW to r5, then PADDSB result 0 -> mem_mem_ren=1, mem_wr_reg=5, then flags unchanged after PADDSB.
